// File: rtl/usb_bulk_in_packetiser.sv
// Byte FIFO that offers MAX_PACKET chunks to the USB core's bulk-IN stream port and holds each chunk until ACKed.
// Optional short-packet flush on idle timeout: define USB_BULK_FLUSH_TIMEOUT_EN.
module usb_bulk_in_packetiser #(
  parameter int ENDPOINT   = 1,
  parameter int MAX_PACKET = 512,
  parameter int DEPTH      = 2048,
  parameter int TIMEOUT    = 4096
) (
  input  logic                       clock,
  input  logic                       areset_n,
  input  logic                       s_tvalid_i,
  output logic                       s_tready_o,
  input  logic [7:0]                 s_tdata_i,
  input  logic                       blk_start_i,
  input  logic                       blk_cycle_i,
  input  logic [3:0]                 blk_endpt_i,
  input  logic                       blk_ack_i,
  output logic                       blk_in_ready_o,
  output logic                       m_axis_tvalid_o,
  input  logic                       m_axis_tready_i,
  output logic                       m_axis_tlast_o,
  output logic [7:0]                 m_axis_tdata_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int ABITS = $clog2(DEPTH);
  localparam logic [ABITS:0] MAX_LEN    = (ABITS+1)'(MAX_PACKET);
  localparam logic [ABITS:0] FULL_LEVEL = {1'b1, {ABITS{1'b0}}};
  localparam logic [ABITS:0] ONE        = (ABITS+1)'(1);
  localparam logic [3:0]     EP_ID      = 4'(ENDPOINT);

  typedef enum logic [1:0] {ST_IDLE, ST_READY, ST_SEND, ST_WAIT} state_t;

  state_t         r_state, w_state_next;
  logic [7:0]     r_mem [DEPTH];
  logic [ABITS:0] r_wr_ptr, r_base_ptr, r_rd_ptr;
  logic [ABITS:0] r_pkt_len, r_count;
  logic           r_alive;
  logic           r_tvalid, r_tlast;
  logic [7:0]     r_tdata;

  logic           w_write, w_beat, w_start, w_flush;
  logic           w_load, w_commit, w_rewind;
  logic [ABITS:0] w_level, w_pending, w_rd_addr, w_count_after;

  // Bytes sent but not yet ACKed still count as occupied, so they can never be overwritten.
  assign w_level       = r_wr_ptr - r_base_ptr;
  assign w_pending     = r_wr_ptr - r_rd_ptr;
  assign s_tready_o    = r_alive & (w_level != FULL_LEVEL);
  assign w_write       = s_tvalid_i & s_tready_o;
  assign w_beat        = r_tvalid & m_axis_tready_i;
  assign w_start       = blk_start_i & blk_cycle_i & (blk_endpt_i == EP_ID);
  assign w_rd_addr     = r_rd_ptr + {{ABITS{1'b0}}, w_beat};
  assign w_count_after = r_count - {{ABITS{1'b0}}, w_beat};

  assign blk_in_ready_o  = (r_state == ST_READY);
  assign m_axis_tvalid_o = r_tvalid;
  assign m_axis_tlast_o  = r_tlast;
  assign m_axis_tdata_o  = r_tdata;
  assign level_o         = w_level;

`ifdef USB_BULK_FLUSH_TIMEOUT_EN
  localparam int TBITS = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TBITS-1:0] TIMEOUT_LAST = TBITS'(TIMEOUT - 1);
  logic [TBITS-1:0] r_idle_cnt;

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      r_idle_cnt <= '0;
    end else if (w_write || r_state != ST_IDLE) begin
      r_idle_cnt <= '0;
    end else if (w_pending != '0 && w_pending < MAX_LEN) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign w_flush = (r_idle_cnt == TIMEOUT_LAST) && (w_pending != '0);
`else
  assign w_flush = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_commit     = 1'b0;
    w_rewind     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pending >= MAX_LEN || w_flush) w_state_next = ST_READY;
      end
      ST_READY: begin
        if (w_start) begin
          w_state_next = ST_SEND;
          w_load       = 1'b1;
        end
      end
      ST_SEND: begin
        if (!blk_cycle_i) begin
          w_state_next = ST_IDLE;
          w_rewind     = 1'b1;
        end else if (w_beat && r_count == ONE) begin
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (blk_ack_i) begin
          w_state_next = ST_IDLE;
          w_commit     = 1'b1;
        end else if (!blk_cycle_i) begin
          w_state_next = ST_IDLE;
          w_rewind     = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      r_state    <= ST_IDLE;
      r_alive    <= 1'b0;
      r_wr_ptr   <= '0;
      r_base_ptr <= '0;
      r_rd_ptr   <= '0;
      r_pkt_len  <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_next;
      r_alive <= 1'b1;
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (r_state == ST_IDLE && w_state_next == ST_READY)
        r_pkt_len <= (w_pending >= MAX_LEN) ? MAX_LEN : w_pending;
      if (w_load)
        r_count <= r_pkt_len;
      else if (r_state == ST_SEND && w_beat)
        r_count <= r_count - ONE;
      if (w_rewind)
        r_rd_ptr <= r_base_ptr;
      else if (r_state == ST_SEND && w_beat)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_commit) r_base_ptr <= r_base_ptr + r_pkt_len;
    end
  end

  // NOTE: the storage array has no reset; only the pointers define which bytes are valid.
  always_ff @(posedge clock) begin
    if (w_write) r_mem[r_wr_ptr[ABITS-1:0]] <= s_tdata_i;
  end

  // Read address looks one byte ahead on an accepted beat, so data streams without bubbles
  // and simply re-reads the same byte while the core stalls.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
    end else if (r_state == ST_SEND && blk_cycle_i && !(w_beat && r_count == ONE)) begin
      r_tvalid <= 1'b1;
      r_tlast  <= (w_count_after == ONE);
      r_tdata  <= r_mem[w_rd_addr[ABITS-1:0]];
    end else begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_bulk_in_packetiser.sv
// Self-checking bench for usb_bulk_in_packetiser; a byte scoreboard holds every written byte until its packet is ACKed.
module tb_usb_bulk_in_packetiser;

  localparam int DEPTH = 2048;
  localparam int MAXP  = 512;
  localparam int ABITS = $clog2(DEPTH);

  logic             clock = 1'b0;
  logic             areset_n;
  logic             s_tvalid_i;
  logic             s_tready_o;
  logic [7:0]       s_tdata_i;
  logic             blk_start_i;
  logic             blk_cycle_i;
  logic [3:0]       blk_endpt_i;
  logic             blk_ack_i;
  logic             blk_in_ready_o;
  logic             m_axis_tvalid_o;
  logic             m_axis_tready_i;
  logic             m_axis_tlast_o;
  logic [7:0]       m_axis_tdata_o;
  logic [ABITS:0]   level_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  usb_bulk_in_packetiser #(
    .ENDPOINT(1), .MAX_PACKET(MAXP), .DEPTH(DEPTH), .TIMEOUT(16)
  ) dut (
    .clock(clock), .areset_n(areset_n),
    .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o), .s_tdata_i(s_tdata_i),
    .blk_start_i(blk_start_i), .blk_cycle_i(blk_cycle_i), .blk_endpt_i(blk_endpt_i),
    .blk_ack_i(blk_ack_i), .blk_in_ready_o(blk_in_ready_o),
    .m_axis_tvalid_o(m_axis_tvalid_o), .m_axis_tready_i(m_axis_tready_i),
    .m_axis_tlast_o(m_axis_tlast_o), .m_axis_tdata_o(m_axis_tdata_o),
    .level_o(level_o)
  );

  always #5 clock = ~clock;

  task automatic write_bytes(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      @(negedge clock);
      s_tvalid_i = 1'b1;
      s_tdata_i  = 8'(first + i);
      while (!s_tready_o && guard < 1000) begin
        @(negedge clock);
        guard++;
      end
      if (guard >= 1000) begin
        checks++; errors++;
        $display("FAIL write_timeout: s_tready_o stuck at %0b, needed 1", s_tready_o);
        break;
      end
      exp_q.push_back(s_tdata_i);
    end
    @(negedge clock);
    s_tvalid_i = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int limit);
    int n = 0;
    while (!blk_in_ready_o && n < limit) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (blk_in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s: blk_in_ready_o=%0b after %0d cycles, needed 1", name, blk_in_ready_o, n);
    end
  endtask

  task automatic do_start(input logic [3:0] ep, input logic expect_send);
    @(negedge clock);
    m_axis_tready_i = 1'b0;
    blk_cycle_i     = 1'b1;
    blk_start_i     = 1'b1;
    blk_endpt_i     = ep;
    @(negedge clock);
    blk_start_i = 1'b0;
    checks++;
    if (m_axis_tvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL tvalid_early: tvalid=%0b one cycle after start, needed 0", m_axis_tvalid_o);
    end
    @(negedge clock);
    checks++;
    if (m_axis_tvalid_o !== expect_send) begin
      errors++;
      $display("FAIL tvalid_rise: tvalid=%0b two cycles after start (ep %0d), needed %0b",
               m_axis_tvalid_o, ep, expect_send);
    end
  endtask

  // Streams up to len beats and compares each against the scoreboard head; abort_after>0
  // drops blk_cycle_i after that many beats.
  task automatic receive(input string name, input int len, input int abort_after, input bit bp);
    int k = 0;
    int cyc = 0;
    bit holding = 1'b0;
    logic [7:0] hd = '0;
    logic hl = 1'b0;
    while (k < len) begin
      @(negedge clock);
      cyc++;
      if (cyc > 20000) begin
        checks++; errors++;
        $display("FAIL %s_timeout: only %0d of %0d beats", name, k, len);
        break;
      end
      if (holding) begin
        checks++;
        if (m_axis_tvalid_o !== 1'b1 || m_axis_tdata_o !== hd || m_axis_tlast_o !== hl) begin
          errors++;
          $display("FAIL %s_stable: got v=%0b d=%02h l=%0b, needed v=1 d=%02h l=%0b",
                   name, m_axis_tvalid_o, m_axis_tdata_o, m_axis_tlast_o, hd, hl);
        end
      end
      if (abort_after > 0 && k == abort_after) begin
        blk_cycle_i     = 1'b0;
        m_axis_tready_i = 1'b0;
        @(negedge clock);
        checks++;
        if (m_axis_tvalid_o !== 1'b0) begin
          errors++;
          $display("FAIL %s_abort: tvalid=%0b after cycle drop, needed 0", name, m_axis_tvalid_o);
        end
        return;
      end
      m_axis_tready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_axis_tvalid_o && m_axis_tready_i) begin
        checks++;
        if (m_axis_tdata_o !== exp_q[k] || m_axis_tlast_o !== 1'(k == len - 1)) begin
          errors++;
          $display("FAIL %s_beat%0d: got d=%02h l=%0b, needed d=%02h l=%0b",
                   name, k, m_axis_tdata_o, m_axis_tlast_o, exp_q[k], 1'(k == len - 1));
        end
        k++;
      end
      holding = m_axis_tvalid_o && !m_axis_tready_i;
      hd = m_axis_tdata_o;
      hl = m_axis_tlast_o;
    end
    @(negedge clock);
    m_axis_tready_i = 1'b0;
    checks++;
    if (m_axis_tvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: tvalid=%0b after tlast, needed 0", name, m_axis_tvalid_o);
    end
  endtask

  task automatic ack_packet(input int len);
    @(negedge clock);
    blk_ack_i = 1'b1;
    @(negedge clock);
    blk_ack_i   = 1'b0;
    blk_cycle_i = 1'b0;
    repeat (len) void'(exp_q.pop_front());
  endtask

  task automatic check_level(input string name, input int expected);
    checks++;
    if (level_o !== (ABITS+1)'(expected)) begin
      errors++;
      $display("FAIL %s: level_o=%0d, needed %0d", name, level_o, expected);
    end
  endtask

  task automatic test_reset;
    areset_n = 1'b0;
    s_tvalid_i = 1'b0; s_tdata_i = '0;
    blk_start_i = 1'b0; blk_cycle_i = 1'b0; blk_endpt_i = '0; blk_ack_i = 1'b0;
    m_axis_tready_i = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (s_tready_o !== 1'b0 || blk_in_ready_o !== 1'b0 || m_axis_tvalid_o !== 1'b0 ||
        m_axis_tlast_o !== 1'b0 || m_axis_tdata_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: tready=%0b ready=%0b v=%0b l=%0b d=%02h, needed 0 0 0 0 00",
               s_tready_o, blk_in_ready_o, m_axis_tvalid_o, m_axis_tlast_o, m_axis_tdata_o);
    end
    check_level("reset_level", 0);
    areset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (s_tready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready: s_tready_o=%0b after reset, needed 1", s_tready_o);
    end
  endtask

  task automatic test_basic;
    write_bytes(MAXP, 0);
    check_level("basic_level_full", MAXP);
    wait_ready("basic_ready", 4);
    do_start(4'd1, 1'b1);
    receive("basic", MAXP, 0, 1'b1);
    ack_packet(MAXP);
    check_level("basic_level_acked", 0);
    @(negedge clock);
    checks++;
    if (blk_in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: blk_in_ready_o=%0b with empty FIFO, needed 0", blk_in_ready_o);
    end
  endtask

  task automatic test_flush;
    int n = 0;
    write_bytes(10, 8'hA0);
`ifdef USB_BULK_FLUSH_TIMEOUT_EN
    while (!blk_in_ready_o && n < 100) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL flush_delay: blk_in_ready_o after %0d clocks, needed 16", n);
    end
    do_start(4'd1, 1'b1);
    receive("flush", 10, 0, 1'b0);
    ack_packet(10);
    check_level("flush_level", 0);
`else
    repeat (40) begin
      @(negedge clock);
      if (blk_in_ready_o) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL no_flush: blk_in_ready_o high for %0d cycles with 10 bytes, needed 0", n);
    end
    write_bytes(MAXP - 10, 8'hAA);
    wait_ready("topup_ready", 4);
    do_start(4'd1, 1'b1);
    receive("topup", MAXP, 0, 1'b0);
    ack_packet(MAXP);
    check_level("topup_level", 0);
`endif
  endtask

  task automatic test_replay;
    write_bytes(MAXP, 8'h40);
    wait_ready("replay_ready", 4);
    do_start(4'd1, 1'b1);
    receive("replay_first", MAXP, 0, 1'b0);
    @(negedge clock);
    blk_cycle_i = 1'b0;
    @(negedge clock);
    check_level("replay_level_kept", MAXP);
    wait_ready("replay_reready", 4);
    do_start(4'd1, 1'b1);
    receive("replay_second", MAXP, 0, 1'b1);
    ack_packet(MAXP);
    check_level("replay_level_acked", 0);
  endtask

  task automatic test_wrong_endpoint_abort;
    write_bytes(MAXP, 8'h13);
    wait_ready("ep_ready", 4);
    do_start(4'd2, 1'b0);
    repeat (4) @(negedge clock);
    checks++;
    if (m_axis_tvalid_o !== 1'b0 || blk_in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL wrong_ep: tvalid=%0b ready=%0b, needed 0 1", m_axis_tvalid_o, blk_in_ready_o);
    end
    blk_cycle_i = 1'b0;
    blk_ack_i   = 1'b1;
    @(negedge clock);
    blk_ack_i = 1'b0;
    @(negedge clock);
    check_level("stray_ack_level", MAXP);
    do_start(4'd1, 1'b1);
    receive("abort", MAXP, 100, 1'b0);
    @(negedge clock);
    check_level("abort_level", MAXP);
    wait_ready("abort_reready", 4);
    do_start(4'd1, 1'b1);
    receive("after_abort", MAXP, 0, 1'b0);
    ack_packet(MAXP);
    check_level("abort_level_acked", 0);
  endtask

  task automatic test_full;
    check_level("full_start_level", 0);
    write_bytes(DEPTH, 8'h55);
    checks++;
    if (s_tready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_tready: s_tready_o=%0b with full FIFO, needed 0", s_tready_o);
    end
    check_level("full_level", DEPTH);
    wait_ready("full_ready", 4);
    do_start(4'd1, 1'b1);
    receive("full_pkt0", MAXP, 0, 1'b1);
    ack_packet(MAXP);
    check_level("full_level_after_ack", DEPTH - MAXP);
    checks++;
    if (s_tready_o !== 1'b1) begin
      errors++;
      $display("FAIL full_tready_after: s_tready_o=%0b, needed 1", s_tready_o);
    end
    for (int p = 1; p < DEPTH / MAXP; p++) begin
      wait_ready("drain_ready", 4);
      do_start(4'd1, 1'b1);
      receive("drain", MAXP, 0, 1'b0);
      ack_packet(MAXP);
    end
    @(negedge clock);
    check_level("drain_level", 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_replay();
    test_wrong_endpoint_abort();
    test_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
